// File: rtl/tl_burst_arbiter.sv
// Burst-aware round-robin grant engine for one TileLink B/D channel; payload is muxed outside via sel_o.
// Optional macro TL_BURST_ARB_FAST_GRANT_EN makes IDLE transparent (no arbitration bubble).
module tl_burst_arbiter #(
  parameter int NumInputs = 2,
  parameter int DataWidth = 64,
  parameter int SizeWidth = 3,
  parameter int MaxSize   = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumInputs-1:0]           req_valid_i,
  input  logic [NumInputs*SizeWidth-1:0] req_size_i,
  input  logic [NumInputs-1:0]           req_has_data_i,
  output logic [NumInputs-1:0]           req_ready_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NumInputs-1:0]           sel_o,
  output logic                           last_o
);

  localparam int NonBurstSize = $clog2(DataWidth / 8);
  localparam int MaxBeats     = (MaxSize > NonBurstSize) ? 2 ** (MaxSize - NonBurstSize) : 1;
  localparam int LenWidth     = (MaxBeats <= 1) ? 1 : $clog2(MaxBeats);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                r_state, w_state_d;
  logic [LenWidth-1:0]   r_len, w_len_d;
  logic [NumInputs-1:0]  r_last, w_last_d;
  logic [NumInputs-1:0]  w_hi_mask, w_hi_valid, w_pick, w_winner;
  logic [NumInputs-1:0]  w_cur_sel;
  logic [LenWidth-1:0]   w_blen [NumInputs];
  logic [LenWidth-1:0]   w_cur_blen;
  logic                  w_any_valid, w_hs;

  // Requests strictly above the last winner get first pick; otherwise wrap to the lowest index.
  assign w_any_valid = |req_valid_i;
  assign w_hi_mask   = ~((r_last << 1) - NumInputs'(1));
  assign w_hi_valid  = req_valid_i & w_hi_mask;
  assign w_pick      = (|w_hi_valid) ? w_hi_valid : req_valid_i;
  assign w_winner    = w_pick & (~w_pick + NumInputs'(1));

  always_comb begin
    int unsigned sz;
    sz = 0;
    for (int i = 0; i < NumInputs; i++) begin
      w_blen[i] = '0;
      sz = 32'(req_size_i[i*SizeWidth +: SizeWidth]);
      if (req_has_data_i[i] && (sz > 32'(NonBurstSize))) begin
        w_blen[i] = LenWidth'((32'd1 << (sz - 32'(NonBurstSize))) - 32'd1);
      end
    end
  end

  // Handshake: a beat transfers on a clock edge where out_valid_o && out_ready_i;
  // req_ready_o mirrors out_ready_i only on the selected requester, and valid is never withdrawn by the arbiter.
  always_comb begin
    w_state_d   = r_state;
    w_len_d     = r_len;
    w_last_d    = r_last;
    w_cur_sel   = '0;
    out_valid_o = 1'b0;
    w_cur_blen  = '0;

    case (r_state)
      ST_IDLE: begin
`ifdef TL_BURST_ARB_FAST_GRANT_EN
        w_cur_sel   = w_winner;
        out_valid_o = w_any_valid;
`endif
      end
      ST_LOCKED: begin
        w_cur_sel   = r_last;
        out_valid_o = |(req_valid_i & r_last);
      end
      default: ;
    endcase

    for (int i = 0; i < NumInputs; i++) begin
      if (w_cur_sel[i]) w_cur_blen = w_cur_blen | w_blen[i];
    end

    sel_o       = w_cur_sel;
    req_ready_o = w_cur_sel & {NumInputs{out_ready_i}};
    w_hs        = out_valid_o & out_ready_i;
    last_o      = (r_len == '0) ? (w_cur_blen == '0) : (r_len == LenWidth'(1));

    if (w_hs) begin
      w_len_d = (r_len == '0) ? w_cur_blen : (r_len - LenWidth'(1));
    end

    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_last_d = w_winner;
`ifdef TL_BURST_ARB_FAST_GRANT_EN
          // A single-beat message that completes here never needs the lock.
          if (!(w_hs && last_o)) w_state_d = ST_LOCKED;
`else
          w_state_d = ST_LOCKED;
`endif
        end
      end
      ST_LOCKED: begin
        if (w_hs && last_o) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_last  <= NumInputs'(1) << (NumInputs - 1);
    end else begin
      r_state <= w_state_d;
      r_len   <= w_len_d;
      r_last  <= w_last_d;
    end
  end

`ifndef SYNTHESIS
  for (genvar g = 0; g < NumInputs; g++) begin : g_size_chk
    size_within_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_valid_i[g] |-> (32'(req_size_i[g*SizeWidth +: SizeWidth]) <= 32'(MaxSize)));
  end
`endif

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// Self-checking bench for tl_burst_arbiter: three requesters, 64-bit beats, scoreboard of expected {sel, last} per beat.
module tb_tl_burst_arbiter;

  localparam int NI = 3;
`ifdef TL_BURST_ARB_FAST_GRANT_EN
  localparam int B2B_GAP = 1;
`else
  localparam int B2B_GAP = 2;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          tb_valid [NI];
  logic [2:0]    tb_size  [NI];
  logic          tb_hd    [NI];
  logic          tb_ready;

  logic [NI-1:0]   req_valid, req_has_data, req_ready, sel;
  logic [NI*3-1:0] req_size;
  logic            out_valid, last;

  assign req_valid    = {tb_valid[2], tb_valid[1], tb_valid[0]};
  assign req_has_data = {tb_hd[2], tb_hd[1], tb_hd[0]};
  assign req_size     = {tb_size[2], tb_size[1], tb_size[0]};

  tl_burst_arbiter #(
    .NumInputs(NI), .DataWidth(64), .SizeWidth(3), .MaxSize(6)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_size_i(req_size), .req_has_data_i(req_has_data),
    .req_ready_o(req_ready), .out_valid_o(out_valid), .out_ready_i(tb_ready),
    .sel_o(sel), .last_o(last)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int cyc     = 0;
  int hs_cyc_prev = 0;
  int hs_cyc_last = 0;
  logic [NI:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [NI:0] e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && tb_ready === 1'b1) begin
      hs_cnt++;
      hs_cyc_prev = hs_cyc_last;
      hs_cyc_last = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got sel=%b last=%b, expected no beat", sel, last);
      end else begin
        e = exp_q.pop_front();
        if ({sel, last} !== e) begin
          n_fail++;
          $display("FAIL beat: got sel=%b last=%b, expected sel=%b last=%b", sel, last, e[NI:1], e[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // driver: one message of 1..8 beats on input idx, optional random valid gaps between beats
  task automatic send_msg(input int idx, input logic [2:0] size, input logic hd, input bit gaps);
    int beats;
    int t;
    int g;
    bit hs;
    beats = (hd && size > 3) ? (1 << (int'(size) - 3)) : 1;
    tb_size[idx] = size;
    tb_hd[idx]   = hd;
    for (int b = 0; b < beats; b++) begin
      if (gaps && b > 0) begin
        g = $urandom_range(0, 2);
        tb_valid[idx] = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      tb_valid[idx] = 1'b1;
      t  = 0;
      hs = 1'b0;
      while (!hs && t < 200) begin
        @(negedge clk);
        hs = tb_valid[idx] && req_ready[idx];
        @(posedge clk); #1;
        t++;
      end
      if (!hs) begin
        n_tests++; n_fail++;
        $display("FAIL beat_timeout: input %0d beat %0d not accepted within 200 cycles", idx, b);
        b = beats;
      end
    end
    tb_valid[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tb_ready = 1'b1;
    for (int i = 0; i < NI; i++) begin
      tb_valid[i] = 1'b0; tb_size[i] = 3'd3; tb_hd[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready: got %b, expected 000", req_ready); end
    n_tests++; if (sel !== 3'b000) begin n_fail++; $display("FAIL reset_sel: got %b, expected 000", sel); end
    n_tests++; if (last !== 1'b1) begin n_fail++; $display("FAIL reset_last: got %b, expected 1", last); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b, expected 0", out_valid); end
  endtask

  task automatic test_single_ack();
    @(posedge clk); #1;
    tb_size[1] = 3'd3; tb_hd[1] = 1'b0; tb_valid[1] = 1'b1;
    exp_q.push_back({3'b010, 1'b1});
`ifndef TL_BURST_ARB_FAST_GRANT_EN
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_bubble: got out_valid=%b, expected 0", out_valid); end
    @(posedge clk); #1;
`endif
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_grant: got out_valid=%b, expected 1", out_valid); end
    @(posedge clk); #1 tb_valid[1] = 1'b0;
    @(negedge clk);
    n_tests++; if ({out_valid, sel} !== 4'b0000) begin n_fail++; $display("FAIL single_idle: got valid=%b sel=%b, expected 0 000", out_valid, sel); end
  endtask

  task automatic test_burst();
    for (int b = 0; b < 8; b++) exp_q.push_back({3'b001, b == 7});
    exp_q.push_back({3'b010, 1'b1});
    fork
      send_msg(0, 3'd6, 1'b1, 1'b0);
      begin
        repeat (3) begin @(posedge clk); #1; end
        send_msg(1, 3'd3, 1'b0, 1'b0);
      end
    join
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({3'b001, 1'b1});
      exp_q.push_back({3'b010, 1'b1});
      exp_q.push_back({3'b100, 1'b1});
    end
    fork
      repeat (2) send_msg(0, 3'd2, 1'b0, 1'b0);
      repeat (2) send_msg(1, 3'd3, 1'b1, 1'b0);
      repeat (2) send_msg(2, 3'd6, 1'b0, 1'b0);
    join
  endtask

  task automatic test_stall();
    int base;
    bit stall_done;
    base = hs_cnt;
    stall_done = 1'b0;
    for (int b = 0; b < 8; b++) exp_q.push_back({3'b100, b == 7});
    exp_q.push_back({3'b001, 1'b1});
    fork
      begin send_msg(2, 3'd6, 1'b1, 1'b1); stall_done = 1'b1; end
      begin
        repeat (2) begin @(posedge clk); #1; end
        send_msg(0, 3'd3, 1'b0, 1'b0);
      end
      begin
        while (!stall_done) begin
          @(negedge clk);
          if (hs_cnt > base && hs_cnt < base + 8) begin
            n_tests++;
            if (sel !== 3'b100) begin n_fail++; $display("FAIL stall_sel_hold: got %b, expected 100", sel); end
          end
          @(posedge clk); #1 tb_ready = ~tb_ready;
        end
        tb_ready = 1'b1;
      end
    join
    n_tests++;
    if (hs_cnt - base !== 9) begin n_fail++; $display("FAIL stall_hs_count: got %0d, expected 9", hs_cnt - base); end
  endtask

  task automatic test_reset_mid_burst();
    int base;
    int t;
    base = hs_cnt;
    for (int b = 0; b < 3; b++) exp_q.push_back({3'b010, 1'b0});
    @(posedge clk); #1;
    tb_ready = 1'b1; tb_size[1] = 3'd6; tb_hd[1] = 1'b1; tb_valid[1] = 1'b1;
    t = 0;
    while (hs_cnt < base + 3 && t < 100) begin @(posedge clk); t++; end
    n_tests++;
    if (hs_cnt < base + 3) begin n_fail++; $display("FAIL midrst_wait: got %0d beats, expected 3", hs_cnt - base); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b, expected 0", out_valid); end
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_req_ready: got %b, expected 000", req_ready); end
    n_tests++; if ({sel, last} !== 4'b0001) begin n_fail++; $display("FAIL midrst_sel_last: got %b %b, expected 000 1", sel, last); end
    tb_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int b = 0; b < 8; b++) exp_q.push_back({3'b001, b == 7});
    exp_q.push_back({3'b010, 1'b1});
    fork
      send_msg(0, 3'd6, 1'b1, 1'b0);
      send_msg(1, 3'd3, 1'b0, 1'b0);
    join
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({3'b001, 1'b1});
    exp_q.push_back({3'b010, 1'b1});
    fork
      send_msg(0, 3'd3, 1'b0, 1'b0);
      send_msg(1, 3'd1, 1'b1, 1'b0);
    join
    n_tests++;
    if (hs_cyc_last - hs_cyc_prev !== B2B_GAP) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d cycles between handshakes, expected %0d", hs_cyc_last - hs_cyc_prev, B2B_GAP);
    end
  endtask

  initial begin
    test_reset();
    test_single_ack();
    test_burst();
    test_round_robin();
    test_stall();
    test_reset_mid_burst();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d beats outstanding, expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_burst_arbiter.md
# tl_burst_arbiter

Burst-aware round-robin scheduler that shares one TileLink response-direction channel (B or D) between `NumInputs` device links. It grants one requester at a time, counts beats, and holds the grant until the last beat of the message has been accepted. It does not carry the payload. The instantiating socket muxes the payload using `sel_o`. It is the sequencing engine for 1:N and N:1 TileLink sockets and bridges.

## Interface
- `NumInputs`, default 2: number of requesters.
- `DataWidth`, default 64: channel data width in bits.
- `SizeWidth`, default 3: width of the TileLink size field.
- `MaxSize`, default 6: largest log2 message size; sets the beat-counter width to `vbits(2**(MaxSize-log2(DataWidth/8)))`.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `req_valid_i`, input, `NumInputs`: per-requester beat valid.
- `req_size_i`, input, `NumInputs`×`SizeWidth`: per-requester message size, stable for the whole message.
- `req_has_data_i`, input, `NumInputs`: the message carries data, so it is multi-beat when size exceeds one beat.
- `req_ready_o`, output, `NumInputs`: per-requester ready.
- `out_valid_o`, output, 1: muxed beat valid.
- `out_ready_i`, input, 1: downstream ready.
- `sel_o`, output, `NumInputs`: one-hot selected requester, for the payload mux.
- `last_o`, output, 1: the current beat is the final beat of its message.

## Operation
- `NonBurstSize` = log2(DataWidth/8).
- Burst length: `blen` = 0 if `size` ≤ `NonBurstSize` or `!has_data`; otherwise 2^(size−NonBurstSize)−1.
- State machine has two states, IDLE and LOCKED, plus a beat counter `len_q` and a one-hot priority pointer `last_q`.
- Round-robin winner: the first asserted `req_valid_i` found by scanning upward, with wrap, from the index after `last_q`.
- IDLE, default build:
  - `out_valid_o`=0, `req_ready_o`=0.
  - If any request is valid, go to LOCKED with `sel_o`=winner and `last_q`=winner.
- LOCKED:
  - `out_valid_o` = `req_valid_i[sel]`.
  - `req_ready_o[sel]` = `out_ready_i`; all other ready bits are 0.
- A handshake is `out_valid_o && out_ready_i`. On each handshake:
  - If `len_q`==0, load `len_q` with `blen` of the selected requester.
  - Otherwise decrement `len_q`.
- `last_o` = (`len_q`==0) ? (`blen`==0) : (`len_q`==1).
- A handshake with `last_o` set returns the block to IDLE.
- If the selected requester deasserts valid between beats, the block stays LOCKED and `sel_o` is held.
- Non-selected requesters are never granted mid-message, whatever their valid state.
- A requester with `size` > `MaxSize` is a protocol violation. A simulation assertion fires and behaviour is undefined.
- `sel_o` is one-hot while LOCKED and all-zero in IDLE, in the default build.

## Timing
- Reset values:
  - State IDLE, `len_q`=0.
  - `last_q` = bit `NumInputs`−1, so input 0 wins first.
  - `out_valid_o`=0, `req_ready_o`=0, `sel_o`=0, `last_o`=1.
- Default build latency: one arbitration bubble per message. A request valid in cycle N is presented in cycle N+1.
- Back-to-back messages: one idle cycle between the last beat and the next grant.
- Multi-beat messages: one beat per cycle while `out_ready_i` is held high.
- Single-input case (`NumInputs`=1): same timing, and the pointer is trivially constant.
- Reset asserted mid-burst: the block returns immediately to IDLE with `len_q`=0. No partial state survives.

## Configuration
- Macro: `TL_BURST_ARB_FAST_GRANT_EN`.
- Defined: IDLE is transparent, with no arbitration bubble.
  - `sel_o` = combinational winner and `out_valid_o` = any request valid.
  - `req_ready_o[winner]` = `out_ready_i`.
  - A single-beat handshake completes in IDLE and updates `last_q`; the block stays in IDLE.
  - Any other case with a winner (no handshake, or a multi-beat first beat) moves to LOCKED on that winner, so an offered request is never withdrawn.
- Undefined: the bubble behaviour described above.
- The beat accounting is identical in both builds.

## Test plan
- Reset, then a single 8-byte D AccessAck on input 1 (`size`=3, no data) -> granted in cycle 1, one beat, `last_o`=1, back to IDLE in cycle 2.
- Input 0 sends AccessAckData with `size`=6 and `DataWidth`=64 -> 8 beats; `last_o` only on beat 8; input 1 asserts valid mid-burst and is not granted until after beat 8.
- Inputs 0, 1 and 2 all request continuously with single-beat messages -> grants in the order 0, 1, 2, 0 (round robin with wrap).
- Burst of `size`=6 with `out_ready_i` toggling 1,0,1,0 and requester valid gaps -> exactly 8 handshakes, `sel_o` held throughout.
- Reset asserted after 3 of 8 beats -> outputs at their reset values; the next grant starts with `len_q`=0 and input 0 has priority.
- With `TL_BURST_ARB_FAST_GRANT_EN` defined, back-to-back single-beat messages on inputs 0 and 1 -> two handshakes in consecutive cycles, with no idle cycle.
